// File: rtl/mvm_pkg.sv
// mvm_pkg: shared widths, tuser field layout and op codes for the mvm result path.
// tuser layout: {64-bit onehot, 2-bit op, 9-bit addr}.
package mvm_pkg;

  localparam int DATAW    = 512;
  localparam int USERW    = 75;
  localparam int DESTW    = 7;
  localparam int TX_DEPTH = 16;

  localparam int ONEHOT_W = 64;
  localparam int OP_MSB   = 10;
  localparam int OP_LSB   = 9;
  localparam int ADDR_MSB = 8;
  localparam int ADDR_LSB = 0;

  typedef enum logic [1:0] {
    OP_INSTR  = 2'd0,
    OP_REDUCE = 2'd1,
    OP_INPUT  = 2'd2,
    OP_MATRIX = 2'd3
  } mvm_op_e;

  function automatic mvm_op_e tuser_op(input logic [USERW-1:0] tuser);
    return mvm_op_e'(tuser[OP_MSB:OP_LSB]);
  endfunction

endpackage

// File: rtl/mvm_tx_buffer_mem.sv
// mvm_tx_buffer_mem: simple dual-port flit store, one write port, one registered read port.
// Read-during-write to the same address returns the old word; the buffer never relies on it.
module mvm_tx_buffer_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write on demand, read every cycle into the output register
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mvm_tx_buffer.sv
// mvm_tx_buffer: AXI-stream FIFO between the mvm tx port and the network.
// The head flit stays in storage until popped; the registered read port acts as the
// output register, so occupancy counts every flit from push to pop.
// Optional counters stat_flits / stat_stall exist only when MVM_TX_BUFFER_STATS_EN is defined.
module mvm_tx_buffer #(
  parameter int DATAW = mvm_pkg::DATAW,
  parameter int USERW = mvm_pkg::USERW,
  parameter int DESTW = mvm_pkg::DESTW,
  parameter int DEPTH = mvm_pkg::TX_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     axis_rx_tvalid,
  input  logic [DATAW-1:0]         axis_rx_tdata,
  input  logic [USERW-1:0]         axis_rx_tuser,
  input  logic [DESTW-1:0]         axis_rx_tdest,
  output logic                     axis_rx_tready,
  output logic                     axis_tx_tvalid,
  output logic [DATAW-1:0]         axis_tx_tdata,
  output logic [USERW-1:0]         axis_tx_tuser,
  output logic [DESTW-1:0]         axis_tx_tdest,
  input  logic                     axis_tx_tready,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef MVM_TX_BUFFER_STATS_EN
  ,
  output logic [31:0]              stat_flits,
  output logic [31:0]              stat_stall
`endif
);

  import mvm_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int FW = DATAW + USERW + DESTW;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic          push, pop;
  logic          vld_p1;
  logic [FW-1:0] rd_word_p1;

  function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
  endfunction

  assign push       = axis_rx_tvalid && axis_rx_tready;
  assign pop        = vld_p1 && axis_tx_tready;
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};

  // pointer, valid and ready control; valid only covers flits written before this edge,
  // which is exactly what the registered read can return
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      vld_p1         <= 1'b0;
      axis_rx_tready <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      rd_ptr         <= rd_ptr_nxt;
      vld_p1         <= (wr_ptr != rd_ptr_nxt);
      axis_rx_tready <= !ptr_full(wr_ptr_nxt, rd_ptr_nxt);
    end
  end

  // storage -> output register stage
  mvm_tx_buffer_mem #(
    .DEPTH (DEPTH),
    .WIDTH (FW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data ({axis_rx_tdata, axis_rx_tuser, axis_rx_tdest}),
    .rd_addr (rd_ptr_nxt[AW-1:0]),
    .rd_data (rd_word_p1)
  );

  assign axis_tx_tvalid = vld_p1;
  assign {axis_tx_tdata, axis_tx_tuser, axis_tx_tdest} = rd_word_p1;
  assign occupancy = wr_ptr - rd_ptr;

`ifdef MVM_TX_BUFFER_STATS_EN
  // count delivered flits and cycles where the network holds off a valid flit
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      if (pop) stat_flits <= stat_flits + 32'd1;
      if (vld_p1 && !axis_tx_tready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mvm_tx_buffer.sv
// tb_mvm_tx_buffer: scoreboard bench for mvm_tx_buffer. Stimulus records each accepted
// flit with the edge it entered on; a negedge monitor compares the DUT against a queue model.
// Define MVM_TX_BUFFER_STATS_EN to also exercise the statistics counters.
module tb_mvm_tx_buffer;
  localparam int DW    = mvm_pkg::DATAW;
  localparam int UW    = mvm_pkg::USERW;
  localparam int TW    = mvm_pkg::DESTW;
  localparam int DEPTH = 16;
  localparam int OW    = $clog2(DEPTH) + 1;
  localparam int FW    = DW + UW + TW;

  typedef struct {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [TW-1:0] t;
    int            edge_n;
  } flit_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          axis_rx_tvalid = 1'b0;
  logic [DW-1:0] axis_rx_tdata = '0;
  logic [UW-1:0] axis_rx_tuser = '0;
  logic [TW-1:0] axis_rx_tdest = '0;
  logic          axis_rx_tready;
  logic          axis_tx_tvalid;
  logic [DW-1:0] axis_tx_tdata;
  logic [UW-1:0] axis_tx_tuser;
  logic [TW-1:0] axis_tx_tdest;
  logic          axis_tx_tready = 1'b0;
  logic [OW-1:0] occupancy;
`ifdef MVM_TX_BUFFER_STATS_EN
  logic [31:0]   stat_flits, stat_stall;
  logic [31:0]   sf, ss;
`endif

  mvm_tx_buffer #(.DATAW(DW), .USERW(UW), .DESTW(TW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .axis_rx_tvalid (axis_rx_tvalid),
    .axis_rx_tdata  (axis_rx_tdata),
    .axis_rx_tuser  (axis_rx_tuser),
    .axis_rx_tdest  (axis_rx_tdest),
    .axis_rx_tready (axis_rx_tready),
    .axis_tx_tvalid (axis_tx_tvalid),
    .axis_tx_tdata  (axis_tx_tdata),
    .axis_tx_tuser  (axis_tx_tuser),
    .axis_tx_tdest  (axis_tx_tdest),
    .axis_tx_tready (axis_tx_tready),
    .occupancy      (occupancy)
`ifdef MVM_TX_BUFFER_STATS_EN
    ,
    .stat_flits     (stat_flits),
    .stat_stall     (stat_stall)
`endif
  );

  initial forever #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            pops = 0;
  int            rmode = 0;        // 0: ready low, 1: ready high, 2: random
  int            pulse_req = 0;
  int            pulse_done = 0;
  bit            armed = 0;
  bit            rst_prev = 1;
  bit            stall_prev = 0;
  logic [FW-1:0] held;
  flit_t         q[$];

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW; i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [UW-1:0] rand_user();
    logic [95:0] v;
    v = {$urandom, $urandom, $urandom};
    return v[UW-1:0];
  endfunction

  // one monitor step at the negedge: compare, then advance the model across the next edge
  task automatic mon_step();
    bit ev;
    ev = (q.size() > 0) && (q[0].edge_n <= cyc - 1);
    if (armed) begin
      chk("occupancy", occupancy, q.size());
      chk("rx_tready", axis_rx_tready, (!rst_prev && q.size() < DEPTH));
      chk("tx_tvalid", axis_tx_tvalid, ev);
      if (ev && axis_tx_tvalid)
        chk("payload", {axis_tx_tdata, axis_tx_tuser, axis_tx_tdest}, {q[0].d, q[0].u, q[0].t});
      if (stall_prev && axis_tx_tvalid)
        chk("stable", {axis_tx_tdata, axis_tx_tuser, axis_tx_tdest}, held);
`ifdef MVM_TX_BUFFER_STATS_EN
      chk("stat_flits", stat_flits, sf);
      chk("stat_stall", stat_stall, ss);
`endif
    end
    if (rst) begin
      q.delete();
      armed      = 1;
      rst_prev   = 1;
      stall_prev = 0;
`ifdef MVM_TX_BUFFER_STATS_EN
      sf = '0;
      ss = '0;
`endif
    end else begin
      rst_prev   = 0;
      stall_prev = ev && !axis_tx_tready;
      held       = {axis_tx_tdata, axis_tx_tuser, axis_tx_tdest};
`ifdef MVM_TX_BUFFER_STATS_EN
      if (ev && axis_tx_tready) sf = sf + 32'd1;
      if (ev && !axis_tx_tready) ss = ss + 32'd1;
`endif
      if (ev && axis_tx_tready) begin
        void'(q.pop_front());
        pops++;
      end
    end
  endtask

  // all send/idle/drain tasks start and end 2 time units after a rising edge
  task automatic send(input logic [DW-1:0] d, input logic [UW-1:0] u, input logic [TW-1:0] t);
    bit ok = 0;
    axis_rx_tvalid = 1'b1;
    axis_rx_tdata  = d;
    axis_rx_tuser  = u;
    axis_rx_tdest  = t;
    for (int w = 0; w < 200 && !ok; w++) begin
      #6;
      if (axis_rx_tready && !rst) begin
        q.push_back('{d, u, t, cyc + 1});
        ok = 1;
      end
      @(posedge clk); #2;
    end
    axis_rx_tvalid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle();
    axis_rx_tvalid = 1'b0;
    axis_rx_tdata  = rand_data();
    axis_rx_tuser  = rand_user();
    axis_rx_tdest  = TW'($urandom);
    @(posedge clk); #2;
  endtask

  task automatic drain();
    int w = 0;
    rmode = 1;
    while (q.size() != 0 && w < 3000) begin
      @(posedge clk); #2;
      w++;
    end
    chk("drain", q.size(), 0);
    idle();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        mon_step();
      end
      forever begin
        @(posedge clk); #3;
        if (pulse_req != pulse_done) begin
          axis_tx_tready = 1'b1;
          pulse_done++;
        end else if (rmode == 2) axis_tx_tready = 1'($urandom_range(0, 1));
        else axis_tx_tready = (rmode == 1);
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, tests %0d", tests);
        $fatal(1, "watchdog expired");
      end
      begin
        logic [15:0] od [4];
        logic [TW-1:0] odst [4];
        int p0;
        od   = '{16'h1B1B, 16'h1818, 16'h1515, 16'h1212};
        odst = '{TW'(1), TW'(2), TW'(1), TW'(2)};

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        idle();

        // arrival order with op=input, ready held high
        rmode = 1;
        idle();
        for (int i = 0; i < 4; i++)
          send(DW'(od[i]), {64'h1 << (i * 7), mvm_pkg::OP_INPUT, 9'(i + 5)}, odst[i]);
        idle();
        drain();

        // fill with the network stalled, then a single-cycle pop while the source waits
        rmode = 0;
        idle();
        for (int i = 0; i < DEPTH; i++) send(rand_data(), rand_user(), TW'($urandom));
        chk("fill_occupancy", occupancy, DEPTH);
        chk("fill_rx_tready", axis_rx_tready, 0);
        fork
          send(rand_data(), rand_user(), TW'(17));
          begin
            repeat (3) @(posedge clk);
            #2;
            chk("held_occupancy", occupancy, DEPTH);
            chk("held_rx_tready", axis_rx_tready, 0);
            pulse_req++;
          end
        join
        chk("refill_occupancy", occupancy, DEPTH);
        drain();

        // long random stall run with incrementing tdata
        p0 = pops;
        rmode = 2;
        for (int i = 0; i < 400; i++) begin
          send(DW'(i), rand_user(), TW'($urandom));
          if ($urandom_range(0, 3) == 0) idle();
        end
        drain();
        chk("stall_pop_count", pops - p0, 400);

        // reset with flits held
        rmode = 0;
        idle();
        for (int i = 0; i < 5; i++) send(rand_data(), rand_user(), TW'($urandom));
        chk("pre_reset_occupancy", occupancy, 5);
        reset_pulse();
        chk("post_reset_tvalid", axis_tx_tvalid, 0);
        chk("post_reset_occupancy", occupancy, 0);
        rmode = 1;
        repeat (10) idle();
        for (int i = 0; i < 3; i++) send(rand_data(), rand_user(), TW'($urandom));
        drain();

`ifdef MVM_TX_BUFFER_STATS_EN
        // 10 delivered flits, then exactly 3 stalled cycles
        reset_pulse();
        rmode = 1;
        idle();
        for (int i = 0; i < 10; i++) send(rand_data(), rand_user(), TW'($urandom));
        drain();
        chk("stats_flits10", stat_flits, 10);
        chk("stats_stall0", stat_stall, 0);
        rmode = 0;
        idle();
        send(rand_data(), rand_user(), TW'($urandom));
        for (int w = 0; w < 20 && !axis_tx_tvalid; w++) idle();
        chk("stats_valid_seen", axis_tx_tvalid, 1);
        repeat (3) idle();
        chk("stats_stall3", stat_stall, 3);
        chk("stats_flits_hold", stat_flits, 10);
        drain();
`endif
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
